pattern_sequencer: RTL
======================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 6, number of selectable shader patterns (2..8).
REQ-002 Parameter AUTO_FRAMES, default 120, frames per pattern in auto-advance mode (>=2).
REQ-003 Parameter CNT_W, default 12, width of hcount/vcount.
REQ-004 i_pixclk  in  1  pixel clock; all logic on its rising edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_rd  in  1  encoder pixel-consume strobe.
REQ-007 i_newline  in  1  encoder start-of-line pulse.
REQ-008 i_newframe  in  1  encoder start-of-frame pulse.
REQ-009 i_btn_next  in  1  asynchronous button, active-high.
REQ-010 i_btn_prev  in  1  asynchronous button, active-high.
REQ-011 i_auto_en  in  1  level; enables timed auto-advance.
REQ-012 o_hcount  out  CNT_W  pixel column counter.
REQ-013 o_vcount  out  CNT_W  line counter.
REQ-014 o_pattern_sel  out  3  active pattern index, 0..NUM_PATTERNS-1.
REQ-015 o_mute  out  1  high: downstream forces pixel to black.
REQ-016 o_switch  out  1  one-cycle pulse when o_pattern_sel changes.

Function
REQ-017 The block SHALL pass each button through a 2-flop synchronizer followed by a rising-edge detector; a request is raised one cycle after the edge appears at the second flop's output.
REQ-018 The FSM SHALL have states RUN, PEND, BLANK.
REQ-019 RUN: next-edge records dir=+1, prev-edge records dir=-1, and the FSM moves to PEND; simultaneous next and prev edges are ignored.
REQ-020 PEND: a new valid request overwrites dir (last wins); on i_newframe the FSM applies dir to o_pattern_sel, pulses o_switch in that same cycle, asserts o_mute, and enters BLANK.
REQ-021 BLANK: o_mute stays high for exactly one full frame; on the next i_newframe o_mute clears and the FSM returns to RUN; button requests during BLANK are discarded.
REQ-022 Index arithmetic SHALL wrap: +1 from NUM_PATTERNS-1 gives 0; -1 from 0 gives NUM_PATTERNS-1.
REQ-023 Frame counter: it SHALL increment on each i_newframe in RUN and clear on any switch or when i_auto_en is low; when i_auto_en is high and the counter equals AUTO_FRAMES-1 at i_newframe, a +1 request is raised and the FSM enters PEND (it switches on the following i_newframe).
REQ-024 A button request and an auto request in the same cycle: the button request SHALL take precedence.
REQ-025 o_vcount SHALL clear on i_newframe, else increment on i_newline; o_hcount SHALL clear on i_newline, else increment on i_rd; clear beats increment; both wrap modulo 2^CNT_W.
REQ-026 i_newframe and i_newline together SHALL clear both counters.
REQ-027 All outputs SHALL be registered; o_mute and o_pattern_sel change only in a cycle where i_newframe is high.

Reset
REQ-028 Assertion of i_reset_n low SHALL immediately force o_hcount=0, o_vcount=0, o_pattern_sel=0, o_mute=1, o_switch=0, FSM=BLANK, frame counter=0, synchronizers=0 and any pending request cleared.
REQ-029 After release, o_mute SHALL clear at the second i_newframe, so the first partial frame is always muted.
REQ-030 Reset asserted mid-PEND SHALL discard the pending request; no o_switch pulse is emitted.

Verification
REQ-031 Reset release, 3 frames, no buttons -> sel=0, mute 1 until 2nd newframe then 0, no o_switch.
REQ-032 Next press mid-frame with sel=5, NUM_PATTERNS=6 -> at next newframe sel=0, one o_switch pulse, mute for one frame.
REQ-033 Prev press then next press in the same frame from sel=0 -> sel=1 at newframe (last wins); both same cycle -> no change.
REQ-034 auto_en=1, AUTO_FRAMES=4 -> sel advances 0->1 on 5th newframe; press during BLANK ignored.
REQ-035 Line of 640 rd pulses then newline -> hcount reaches 640 then 0; newframe+newline together -> hcount=vcount=0.
REQ-036 Reset pulsed while in PEND -> sel stays 0, o_switch never pulses, mute=1 immediately.

Source files
------------

// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
//
// Tracks the raster position of a pixel encoder and selects which of
// NUM_PATTERNS shader patterns is shown. Pattern changes are requested by two
// asynchronous push-buttons (next / prev) or by a timed auto-advance. A change
// is held pending until the next start of frame, applied there, and then the
// picture is muted for one full frame so no torn frame is ever displayed.
//
// Ports
//   i_pixclk       in   1      pixel clock, all logic on its rising edge
//   i_reset_n      in   1      asynchronous active-low reset
//   i_rd           in   1      encoder pixel-consume strobe (advances hcount)
//   i_newline      in   1      encoder start-of-line pulse
//   i_newframe     in   1      encoder start-of-frame pulse
//   i_btn_next     in   1      asynchronous button, active-high, index +1
//   i_btn_prev     in   1      asynchronous button, active-high, index -1
//   i_auto_en      in   1      level, enables timed auto-advance
//   o_hcount       out  CNT_W  pixel column counter
//   o_vcount       out  CNT_W  line counter
//   o_pattern_sel  out  3      active pattern index, 0..NUM_PATTERNS-1
//   o_mute         out  1      high: downstream forces the pixel to black
//   o_switch       out  1      one-cycle pulse when o_pattern_sel changes
// -----------------------------------------------------------------------------
module pattern_sequencer #(
  parameter int NUM_PATTERNS = 6,    // 2..8
  parameter int AUTO_FRAMES  = 120,  // frames per pattern in auto mode, >= 2
  parameter int CNT_W        = 12
) (
  input  logic             i_pixclk,
  input  logic             i_reset_n,
  input  logic             i_rd,
  input  logic             i_newline,
  input  logic             i_newframe,
  input  logic             i_btn_next,
  input  logic             i_btn_prev,
  input  logic             i_auto_en,
  output logic [CNT_W-1:0] o_hcount,
  output logic [CNT_W-1:0] o_vcount,
  output logic [2:0]       o_pattern_sel,
  output logic             o_mute,
  output logic             o_switch
);

  localparam int         FC_W     = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(AUTO_FRAMES - 1);
  localparam logic [2:0]      SEL_LAST = 3'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t          state, state_d;
  logic            dir_up, dir_up_d;          // pending direction, 1 = +1
  logic            blank_partial, partial_d;  // BLANK entered from reset, mid-frame
  logic [FC_W-1:0] frame_cnt, frame_cnt_d;
  logic [2:0]      sel_d;
  logic            mute_d;
  logic            switch_d;

  // ---------------------------------------------------------------------------
  // Button synchronizers: [0],[1] are the two synchronizing flops, [2] is the
  // delayed copy of [1] used for rising-edge detection. The edge is registered
  // so a request appears one cycle after the edge reaches the second flop.
  // ---------------------------------------------------------------------------
  logic [2:0] next_sync, prev_sync;
  logic       req_next, req_prev;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      next_sync <= 3'b000;
      prev_sync <= 3'b000;
      req_next  <= 1'b0;
      req_prev  <= 1'b0;
    end else begin
      next_sync <= {next_sync[1:0], i_btn_next};
      prev_sync <= {prev_sync[1:0], i_btn_prev};
      req_next  <= next_sync[1] & ~next_sync[2];
      req_prev  <= prev_sync[1] & ~prev_sync[2];
    end
  end

  // Simultaneous next and prev cancel each other out.
  logic valid_next, valid_prev, dir_eff, auto_req;

  assign valid_next = req_next & ~req_prev;
  assign valid_prev = req_prev & ~req_next;
  // A fresh request in PEND overrides the stored direction (last one wins).
  assign dir_eff    = valid_next ? 1'b1 : (valid_prev ? 1'b0 : dir_up);
  assign auto_req   = i_auto_en & i_newframe & (frame_cnt == FC_LAST);

  function automatic logic [2:0] step_sel(input logic [2:0] cur, input logic up);
    if (up) return (cur == SEL_LAST) ? 3'd0 : cur + 3'd1;
    else    return (cur == 3'd0) ? SEL_LAST : cur - 3'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_BLANK;
      dir_up        <= 1'b0;
      blank_partial <= 1'b1;
    end else begin
      state         <= state_d;
      dir_up        <= dir_up_d;
      blank_partial <= partial_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    dir_up_d  = dir_up;
    partial_d = blank_partial;
    case (state)
      S_RUN: begin
        // Button requests take precedence over the auto-advance request.
        if (valid_next || valid_prev) begin
          dir_up_d = valid_next;
          state_d  = S_PEND;
        end else if (auto_req) begin
          dir_up_d = 1'b1;
          state_d  = S_PEND;
        end
      end
      S_PEND: begin
        dir_up_d = dir_eff;
        if (i_newframe) state_d = S_BLANK;
      end
      S_BLANK: begin
        // After reset the first frame is partial; it must run out before the
        // one full muted frame starts, so the first newframe only arms BLANK.
        if (i_newframe) begin
          if (blank_partial) partial_d = 1'b0;
          else               state_d   = S_RUN;
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d       = o_pattern_sel;
    mute_d      = o_mute;
    switch_d    = 1'b0;
    frame_cnt_d = frame_cnt;

    if (state == S_PEND && i_newframe) begin
      sel_d    = step_sel(o_pattern_sel, dir_eff);
      switch_d = 1'b1;
      mute_d   = 1'b1;
    end

    if (state == S_BLANK && i_newframe && !blank_partial) mute_d = 1'b0;

    // Counts frames spent in RUN; stops once a request moves the FSM to PEND.
    if (!i_auto_en || switch_d)
      frame_cnt_d = '0;
    else if (state == S_RUN && i_newframe && state_d == S_RUN)
      frame_cnt_d = frame_cnt + 1'b1;
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pattern_sel <= 3'd0;
      o_mute        <= 1'b1;
      o_switch      <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      o_pattern_sel <= sel_d;
      o_mute        <= mute_d;
      o_switch      <= switch_d;
      frame_cnt     <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster counters: clear beats increment, both wrap modulo 2^CNT_W.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hcount <= '0;
      o_vcount <= '0;
    end else begin
      if (i_newframe)     o_vcount <= '0;
      else if (i_newline) o_vcount <= o_vcount + 1'b1;

      if (i_newline)      o_hcount <= '0;
      else if (i_rd)      o_hcount <= o_hcount + 1'b1;
    end
  end

endmodule
